// File: rtl/filter_seq_pkg.sv
// Shared types and constants for the band-pass filter sequencer.
// Imported by filter_sequencer and freq_glide.
package filter_seq_pkg;

    localparam int N_DEFAULT = 10;

    localparam logic FILT_LPF = 1'b0;
    localparam logic FILT_HPF = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        H_DRIVE,
        H_CAP,
        L_DRIVE,
        L_CAP,
        DONE
    } state_t;

    // Unsigned midscale, i.e. the code that represents DC zero
    function automatic int midscale(input int n);
        return 2 ** (n - 1);
    endfunction

endpackage

// File: rtl/freq_glide.sv
// Slew-limited cutoff register: moves toward the pot value by at most STEP
// each time advance is pulsed. Used only when FILTER_SEQ_GLIDE_EN is defined.
module freq_glide
    import filter_seq_pkg::*;
#(
    parameter int STEP = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    input  logic [15:0] target,
    output logic [15:0] f_eff
);

    localparam logic [15:0] STEP_W = 16'(STEP);

    logic [15:0] diff;
    logic [15:0] f_next;

    always_comb begin
        diff   = '0;
        f_next = f_eff;
        if (target >= f_eff) begin
            diff   = target - f_eff;
            f_next = (diff > STEP_W) ? f_eff + STEP_W : target;
        end else begin
            diff   = f_eff - target;
            f_next = (diff > STEP_W) ? f_eff - STEP_W : target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_eff <= '0;
        end else if (advance) begin
            f_eff <= f_next;
        end
    end

endmodule

// File: rtl/filter_sequencer.sv
// Time-shares one combinational first-order datapath between an HPF and an
// LPF stage per sample. Optional cutoff glide: define FILTER_SEQ_GLIDE_EN.
module filter_sequencer
    import filter_seq_pkg::*;
#(
    parameter int N          = N_DEFAULT,
    parameter int MID        = midscale(N),
    parameter int GLIDE_STEP = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           sample_valid,
    input  logic [N-1:0]   sample_in,
    output logic           sample_ready,
    input  logic [15:0]    f_hpf,
    input  logic [15:0]    f_lpf,
    input  logic           hpf_en,
    input  logic           lpf_en,
    output logic           out_valid,
    output logic [N-1:0]   out_data,
    output logic [7:0]     overrun_cnt,
    output logic [2*N-1:0] dp_x,
    output logic [N-1:0]   dp_y,
    output logic [15:0]    dp_f,
    output logic           dp_filt_type,
    input  logic [N-1:0]   dp_out
);

    localparam logic [N-1:0] MID_N = N'(MID);

    if (GLIDE_STEP < 1 || GLIDE_STEP > 65535) begin : g_bad_glide_step
        $error("filter_sequencer: GLIDE_STEP must be in 1..65535");
    end

    state_t       state;
    state_t       state_next;
    logic [N-1:0] xin;
    logic [N-1:0] hx1;
    logic [N-1:0] hy1;
    logic [N-1:0] lx1;
    logic [N-1:0] ly1;
    logic [N-1:0] mid;
    logic [15:0]  f_hpf_eff;
    logic [15:0]  f_lpf_eff;
    logic         accept;
    logic         drop;
    logic         stage_en;
    logic [N-1:0] stage_x;
    logic [N-1:0] result;

    assign sample_ready = (state == IDLE);
    assign accept       = sample_valid && (state == IDLE);
    assign drop         = sample_valid && (state != IDLE);

    // A bypassed stage passes its input straight through, but still feeds
    // the history update below so re-enabling it does not click.
    assign stage_en = (state == H_CAP) ? hpf_en : lpf_en;
    assign stage_x  = (state == H_CAP) ? xin : mid;
    assign result   = stage_en ? dp_out : stage_x;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        dp_x         = '0;
        dp_y         = '0;
        dp_f         = '0;
        dp_filt_type = FILT_LPF;
        out_valid    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = H_DRIVE;
                end
            end
            H_DRIVE, H_CAP: begin
                state_next   = (state == H_DRIVE) ? H_CAP : L_DRIVE;
                dp_x         = {hx1, xin};
                dp_y         = hy1;
                dp_f         = f_hpf_eff;
                dp_filt_type = FILT_HPF;
            end
            L_DRIVE, L_CAP: begin
                state_next   = (state == L_DRIVE) ? L_CAP : DONE;
                dp_x         = {lx1, mid};
                dp_y         = ly1;
                dp_f         = f_lpf_eff;
                dp_filt_type = FILT_LPF;
            end
            DONE: begin
                state_next = IDLE;
                out_valid  = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // out_data is loaded on the L_CAP edge so the new value and the
    // out_valid pulse appear together in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xin         <= '0;
            hx1         <= MID_N;
            hy1         <= MID_N;
            lx1         <= MID_N;
            ly1         <= MID_N;
            mid         <= MID_N;
            out_data    <= MID_N;
            overrun_cnt <= '0;
        end else begin
            if (accept) begin
                xin <= sample_in;
            end
            if (drop && overrun_cnt != 8'hFF) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
            if (state == H_CAP) begin
                hx1 <= xin;
                hy1 <= result;
                mid <= result;
            end
            if (state == L_CAP) begin
                lx1      <= mid;
                ly1      <= result;
                out_data <= result;
            end
        end
    end

`ifdef FILTER_SEQ_GLIDE_EN
    freq_glide #(
        .STEP(GLIDE_STEP)
    ) u_hpf_glide (
        .clk(clk),
        .reset(reset),
        .advance(accept),
        .target(f_hpf),
        .f_eff(f_hpf_eff)
    );

    freq_glide #(
        .STEP(GLIDE_STEP)
    ) u_lpf_glide (
        .clk(clk),
        .reset(reset),
        .advance(accept),
        .target(f_lpf),
        .f_eff(f_lpf_eff)
    );
`else
    // Cutoffs are frozen at accept so pot movement mid-sample is ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_hpf_eff <= '0;
            f_lpf_eff <= '0;
        end else if (accept) begin
            f_hpf_eff <= f_hpf;
            f_lpf_eff <= f_lpf;
        end
    end
`endif

endmodule
